// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction memory writer.
//
// Receives a byte stream (2-byte little-endian word count N, then 4*N bytes
// of little-endian instruction words), writes each assembled word to
// consecutive word-aligned IMEM addresses and holds the CPU in reset until
// the whole image is in place.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_data  upstream byte stream
//   in_ready          loader accepts a byte this cycle (registered)
//   imem_we           one-cycle write strobe per completed word
//   imem_waddr        word-aligned byte address of the write
//   imem_wdata        assembled 32-bit instruction word
//   cpu_rst           CPU reset, released once the load completes
//   done              sticky: load completed
//   error             sticky: requested length exceeds IMEM_SIZE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | one cycle after reset before the stream is opened
// LEN_LO  | waiting for the low byte of the word count
// LEN_HI  | waiting for the high byte; length is classified here
// DATA    | collecting data bytes, one write per four bytes
// DONE    | image loaded, CPU released, stream closed
// ERR     | length too large, CPU kept in reset, stream closed

module imem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int IMEM_SIZE     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] LP_SIZE = 17'(IMEM_SIZE);

  state_t                   r_state, w_state_n;
  logic [15:0]              r_len, w_len_n;
  logic [15:0]              r_word_idx, w_word_idx_n;
  logic [1:0]               r_k, w_k_n;
  logic [23:0]              r_word, w_word_n;
  logic                     r_in_ready, w_in_ready_n;
  logic                     r_we, w_we_n;
  logic [ADDRESS_WIDTH-1:0] r_waddr, w_waddr_n;
  logic [DATA_WIDTH-1:0]    r_wdata, w_wdata_n;
  logic                     r_cpu_rst, w_cpu_rst_n;
  logic                     r_done, w_done_n;
  logic                     r_error, w_error_n;

  logic                     w_accept;
  logic [15:0]              w_len_full;

  assign w_accept   = in_valid & r_in_ready;
  assign w_len_full = {in_data, r_len[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_idx <= '0;
      r_k        <= '0;
      r_word     <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_len      <= w_len_n;
      r_word_idx <= w_word_idx_n;
      r_k        <= w_k_n;
      r_word     <= w_word_n;
      r_in_ready <= w_in_ready_n;
      r_we       <= w_we_n;
      r_waddr    <= w_waddr_n;
      r_wdata    <= w_wdata_n;
      r_cpu_rst  <= w_cpu_rst_n;
      r_done     <= w_done_n;
      r_error    <= w_error_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_len_n      = r_len;
    w_word_idx_n = r_word_idx;
    w_k_n        = r_k;
    w_word_n     = r_word;
    w_we_n       = 1'b0;
    w_waddr_n    = r_waddr;
    w_wdata_n    = r_wdata;

    case (r_state)
      S_IDLE: w_state_n = S_LEN_LO;

      S_LEN_LO: begin
        if (w_accept) begin
          w_len_n[7:0] = in_data;
          w_state_n    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (w_accept) begin
          w_len_n[15:8] = in_data;
          if (w_len_full == 16'd0)
            w_state_n = S_DONE;
          else if ({1'b0, w_len_full} > LP_SIZE)
            w_state_n = S_ERR;
          else
            w_state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (w_accept) begin
          w_k_n = r_k + 2'd1;
          case (r_k)
            2'd0: w_word_n[7:0]   = in_data;
            2'd1: w_word_n[15:8]  = in_data;
            2'd2: w_word_n[23:16] = in_data;
            default: begin
              w_we_n       = 1'b1;
              w_wdata_n    = DATA_WIDTH'({in_data, r_word});
              w_waddr_n    = ADDRESS_WIDTH'({r_word_idx, 2'b00});
              w_word_idx_n = r_word_idx + 16'd1;
              if (r_word_idx == r_len - 16'd1)
                w_state_n = S_DONE;
            end
          endcase
        end
      end

      S_DONE: w_state_n = S_DONE;
      S_ERR:  w_state_n = S_ERR;
      default: w_state_n = S_IDLE;
    endcase

    w_in_ready_n = (w_state_n == S_LEN_LO) || (w_state_n == S_LEN_HI) ||
                   (w_state_n == S_DATA);
    // A zero-length image completes on the length edge itself; otherwise
    // done follows one cycle after DONE is entered so the last write is
    // seen before the CPU leaves reset.
    w_done_n     = (r_state == S_DONE) ||
                   ((r_state == S_LEN_HI) && (w_state_n == S_DONE));
    w_error_n    = (w_state_n == S_ERR);
    w_cpu_rst_n  = ~w_done_n;
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SZ = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;

  imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .IMEM_SIZE(SZ)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stream[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: tracks the stream position of every accepted byte and
  // derives what the outputs must look like on the next cycle.
  bit started, e_ready, e_we, e_done, e_err, last_flag, nxt_we;
  int pos, n;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_we", 64'(imem_we), 64'd0);
      check("rst_waddr", 64'(imem_waddr), 64'd0);
      check("rst_wdata", 64'(imem_wdata), 64'd0);
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      started = 0; pos = 0; n = 0;
      e_ready = 0; e_we = 0; e_done = 0; e_err = 0; last_flag = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(e_ready));
      check("imem_we", 64'(imem_we), 64'(e_we));
      check("done", 64'(done), 64'(e_done));
      check("error", 64'(error), 64'(e_err));
      check("cpu_rst", 64'(cpu_rst), 64'(!e_done));
      if (imem_we) begin
        if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
        else begin
          wr_t w;
          w = exp_q.pop_front();
          check("waddr", 64'(imem_waddr), 64'(w.a));
          check("wdata", 64'(imem_wdata), 64'(w.d));
        end
      end
      nxt_we = 0;
      if (last_flag) begin
        e_done = 1;
        last_flag = 0;
      end
      if (!started) begin
        started = 1;
        e_ready = 1;
      end else if (in_valid && e_ready) begin
        if (pos == 0) n = int'(in_data);
        else if (pos == 1) begin
          n = n + int'(in_data) * 256;
          if (n == 0) begin e_done = 1; e_ready = 0; end
          else if (n > SZ) begin e_err = 1; e_ready = 0; end
        end else if ((pos - 2) % 4 == 3) begin
          nxt_we = 1;
          if ((pos - 2) / 4 == n - 1) begin e_ready = 0; last_flag = 1; end
        end
        pos++;
      end
      e_we = nxt_we;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    cycles(3);
    rst = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bubbles);
    bit got;
    int cnt;
    repeat (bubbles) begin
      in_valid = 0;
      cycles(1);
    end
    in_valid = 1;
    in_data  = b;
    cnt = 0;
    do begin
      got = in_ready;
      cycles(1);
      cnt++;
    end while (!got && cnt < 64);
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: no bubbles, 1: one idle cycle before every byte, 2: random
  task automatic send_stream(input int mode);
    int b;
    while (stream.size() > 0) begin
      if (mode == 1) b = 1;
      else if (mode == 2) b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      else b = 0;
      send_byte(stream.pop_front(), b);
    end
    in_valid = 0;
  endtask

  task automatic present_ignored(input int k);
    in_valid = 1;
    repeat (k) begin
      in_data = 8'($urandom);
      cycles(1);
    end
    in_valid = 0;
  endtask

  task automatic push_len(input int len);
    stream.push_back(8'(len & 255));
    stream.push_back(8'((len >> 8) & 255));
  endtask

  task automatic push_word(input logic [31:0] w, input int idx, input bit expect_write);
    for (int i = 0; i < 4; i++) stream.push_back(8'((w >> (8 * i)) & 32'hFF));
    if (expect_write) exp_q.push_back({32'(idx * 4), w});
  endtask

  task automatic basic_n2(input int mode);
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    exp_q.push_back({32'h0, 32'h00500013});
    exp_q.push_back({32'h4, 32'h00A00093});
    send_stream(mode);
    cycles(4);
    check("n2_done", 64'(done), 64'd1);
    check("n2_error", 64'(error), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    cycles(2);
    rst = 0;

    basic_n2(0);
    basic_n2(1);

    do_reset();
    push_len(0);
    send_stream(0);
    cycles(3);
    check("n0_done", 64'(done), 64'd1);
    check("n0_in_ready", 64'(in_ready), 64'd0);

    do_reset();
    push_len(SZ + 1);
    send_stream(0);
    present_ignored(8);
    cycles(2);
    check("err_error", 64'(error), 64'd1);
    check("err_cpu_rst", 64'(cpu_rst), 64'd1);

    do_reset();
    push_len(3);
    push_word(32'h11223344, 0, 1'b1);
    stream.push_back(8'h55);
    stream.push_back(8'h66);
    send_stream(0);
    cycles(2);
    do_reset();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    send_stream(2);
    cycles(3);
    check("reload_done", 64'(done), 64'd1);
    present_ignored(4);
    cycles(2);
    check("post_done_done", 64'(done), 64'd1);
    check("post_done_cpu_rst", 64'(cpu_rst), 64'd0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      len = int'($urandom_range(1, 6));
      push_len(len);
      for (int i = 0; i < len; i++) push_word($urandom, i, 1'b1);
      send_stream(2);
      cycles(3);
      check("rand_done", 64'(done), 64'd1);
    end

    do_reset();
    push_len(SZ);
    for (int i = 0; i < SZ; i++) push_word($urandom, i, 1'b1);
    send_stream(0);
    cycles(3);
    check("max_done", 64'(done), 64'd1);
    check("max_error", 64'(error), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the multithreaded barrel CPU. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive word-aligned IMEM addresses. It holds the CPU in reset until the whole image is loaded. It sits between the host/test stream source and the write port of the CPU's instruction memory.

## Interface
- ADDRESS_WIDTH, 32, width of `imem_waddr` (byte address)
- DATA_WIDTH, 32, width of `imem_wdata`; fixed at 32
- IMEM_SIZE, 1024, IMEM capacity in words; must be ≤ 65535

One clock; reset is asynchronous and active-high.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  `in_data` holds a valid byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_waddr  out  ADDRESS_WIDTH  byte address, word-aligned (word index × 4)
- imem_wdata  out  DATA_WIDTH  assembled instruction word
- cpu_rst  out  1  reset to the CPU core; high until the load completes
- done  out  1  load completed successfully; sticky
- error  out  1  length exceeded IMEM_SIZE; sticky

## Operation
- Stream format: length N as 2 bytes, little-endian (low byte first), then 4·N data bytes; each word is sent little-endian (byte 0 = bits 7:0).
- Transfer rule: a byte is accepted on a rising edge where `in_valid && in_ready`. No other byte is consumed.
- FSM states:
  - IDLE: entered on reset. Goes to LEN_LO unconditionally on the first edge.
  - LEN_LO: on accept, latch N[7:0].
  - LEN_HI: on accept, latch N[15:8]. If N == 0, go to DONE. If N > IMEM_SIZE, go to ERR. Otherwise go to DATA.
  - DATA: 2-bit byte counter k; byte goes into word bits 8k+7:8k. On the accept with k == 3:
    - register `imem_we`=1, `imem_wdata`=assembled word, `imem_waddr`={word_idx, 2'b00} zero-extended
    - increment word_idx (16 bits)
    - if word_idx was N−1, go to DONE
  - DONE: `done`=1, `cpu_rst`=0, `in_ready`=0. Stays here until reset.
  - ERR: `error`=1, `cpu_rst`=1, `in_ready`=0, no writes. Stays here until reset.
- `in_ready` is registered: 1 in LEN_LO, LEN_HI and DATA; 0 in IDLE, DONE and ERR.
- Bytes presented while `in_ready`=0 are ignored. The upstream source holds them; nothing is dropped silently in active states.
- The loader never issues a write at or beyond word IMEM_SIZE.

## Timing
- Reset values (asynchronous): state IDLE, `in_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `error`=0, counters 0.
- First edge after `rst` falls: `in_ready` goes to 1.
- Write latency: `imem_we` is high in the cycle after the edge that accepts the 4th byte of a word. It is high for exactly one cycle unless the next word completes on the following edge; back-to-back writes are not possible since each word needs 4 accepts.
- Completion:
  - N > 0: `done`=1 and `cpu_rst`=0 are registered on the edge after the last `imem_we` cycle begins. The final write is therefore visible one cycle before `cpu_rst` drops.
  - N == 0: `done`=1 and `cpu_rst`=0 are registered on the LEN_HI accept edge.
- Error: `error`=1 and `in_ready`=0 are registered on the LEN_HI accept edge.
- Bubbles: `in_valid` low stalls the FSM with no state change. The partial word and byte counter are held.
- Reset mid-load:
  - all outputs return to reset values immediately
  - IMEM contents already written are left as is
  - a new load starts from LEN_LO
- Maximum N == IMEM_SIZE is legal. The last write goes to address 4·(IMEM_SIZE−1).

## Test plan
- N=2, stream 02 00 13 00 50 00 93 00 A0 00, `in_valid` held high → write (0x0, 0x00500013), then (0x4, 0x00A00093). `done`=1 and `cpu_rst`=0 one cycle after the second write. `error`=0.
- Same stream with `in_valid` low on every other cycle → identical writes and data. Each write still occurs the cycle after its 4th accepted byte.
- N=0, stream 00 00 → no `imem_we` pulse. `done`=1 and `cpu_rst`=0 after the LEN_HI accept edge. `in_ready`=0 afterwards.
- N=1025 (01 04) with IMEM_SIZE=1024 → `error`=1, `in_ready`=0, `cpu_rst` stays 1. No writes, even if further bytes are presented.
- N=3, assert `rst` after 6 data bytes, then send N=1 with word 0xDEADBEEF (01 00 EF BE AD DE) → exactly one write (0x0, 0xDEADBEEF) after the reset, then `done`=1.
- After `done`, present 4 more bytes with `in_valid`=1 → `in_ready` stays 0, no `imem_we`, and `done`/`cpu_rst` are unchanged.
